tt_um_halfadder_serial_ctrl: RTL and testbench
==============================================

TT_UM_HALFADDER_SERIAL_CTRL -- requirements
Module: tt_um_halfadder_serial_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 ena  input  1  design enable; when 0, every register holds its value.
REQ-004 ui_in  input  8  [3:0] operand A, [7:4] operand B, both sampled on accepted start.
REQ-005 uio_in  input  8  [0] start (level, rising-edge detected), [1] mode (0=add, 1=subtract), [7:2] ignored.
REQ-006 uo_out  output  8  [3:0] result, [4] carry_out, [5] overflow, [6] busy, [7] done.
REQ-007 uio_out  output  8  constant 0.
REQ-008 uio_oe  output  8  constant 0 (all bidirectional pins are inputs).

Function
REQ-009 Datapath SHALL be one bit-serial full adder built from two half adders (s = a^b^c; c' = (a&b)|((a^b)&c)) plus a carry flop, reused once per bit.
REQ-010 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-011 start_q SHALL register uio_in[0] each enabled cycle; start_pulse = uio_in[0] & ~start_q.
REQ-012 In IDLE or DONE, start_pulse at an enabled edge SHALL latch A, B^{4{mode}}, mode, carry<=mode, bit count<=0, state<=RUN, done<=0.
REQ-013 In RUN, each enabled edge SHALL process one bit LSB-first: shift-in sum bit to a 4-bit partial register, update carry, shift operands right, increment count.
REQ-014 At the 4th RUN edge (count=3) state SHALL go DONE; result<=final 4 sum bits, carry_out<=final carry, overflow<=carry_into_bit3 ^ final carry.
REQ-015 Latency: start_pulse sampled at edge k -> busy=1 after edge k; done=1 and result valid after edge k+4.
REQ-016 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-017 result, carry_out, overflow SHALL be registers updated only on the RUN->DONE edge; they hold previous values in IDLE and during RUN.
REQ-018 start_pulse during RUN SHALL be ignored; start held high SHALL launch exactly one operation.
REQ-019 DONE SHALL persist until a new start_pulse (DONE->RUN directly).
REQ-020 Subtract: carry-out=1 means no borrow (A>=B unsigned).
REQ-021 ena=0 SHALL freeze FSM, counters, operands, start_q, and outputs; resumption continues exactly where frozen.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, all registers 0, uo_out=0x00, independent of clk and ena.
REQ-023 Reset during RUN SHALL abort the operation; no partial result appears at uo_out.
REQ-024 After rst_n release, start_q=0, so a start held high through reset SHALL launch an operation at the first enabled edge.

Verification
REQ-025 Add A=5,B=3, start pulse -> after 4 edges uo_out[4:0]=0x08, overflow=1, done=1, busy=0.
REQ-026 Add A=15,B=1 -> result=0x0, carry_out=1, overflow=0.
REQ-027 Subtract A=3,B=5 -> result=0xE, carry_out=0, overflow=0; subtract A=5,B=5 -> result=0x0, carry_out=1.
REQ-028 Start held high 20 cycles, operands changed mid-RUN -> exactly one operation, result from operands at accept edge.
REQ-029 rst_n low at RUN edge 2 -> uo_out=0x00 immediately; next start gives correct fresh result.
REQ-030 ena=0 for 3 cycles mid-RUN -> busy held, done delayed by exactly 3 cycles, result unchanged from ena=1 case.

Source files
------------

// File: rtl/tt_um_halfadder_serial_ctrl.sv
// rtl/tt_um_halfadder_serial_ctrl.sv - bit-serial 4-bit add/subtract unit with IDLE/RUN/DONE control
`timescale 1ns/1ps
module tt_um_halfadder_serial_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_start_q;
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic        r_carry;
  logic [1:0]  r_cnt;
  logic [3:0]  r_partial;
  logic [3:0]  r_result;
  logic        r_cout;
  logic        r_ovf;

  logic        w_start_pulse;
  logic        w_mode;
  logic        w_ha1_s;
  logic        w_ha1_c;
  logic        w_sum;
  logic        w_ha2_c;
  logic        w_cout;
  logic        w_last;
  logic        w_unused;

  assign w_start_pulse = uio_in[0] & ~r_start_q;
  assign w_mode        = uio_in[1];
  assign w_last        = (r_cnt == 2'd3);

  // Full adder as two half adders; the carry flop closes the loop between bits.
  assign w_ha1_s = r_a[0] ^ r_b[0];
  assign w_ha1_c = r_a[0] & r_b[0];
  assign w_sum   = w_ha1_s ^ r_carry;
  assign w_ha2_c = w_ha1_s & r_carry;
  assign w_cout  = w_ha1_c | w_ha2_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_pulse) w_next = RUN;
      RUN:     if (w_last)        w_next = DONE;
      DONE:    if (w_start_pulse) w_next = RUN;
      default:                    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_carry   <= 1'b0;
      r_cnt     <= 2'd0;
      r_partial <= 4'd0;
      r_result  <= 4'd0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (ena) begin
      r_start_q <= uio_in[0];
      if (r_state == RUN) begin
        r_partial <= {w_sum, r_partial[3:1]};
        r_carry   <= w_cout;
        r_a       <= {1'b0, r_a[3:1]};
        r_b       <= {1'b0, r_b[3:1]};
        r_cnt     <= r_cnt + 2'd1;
        if (w_last) begin
          r_result <= {w_sum, r_partial[3:1]};
          r_cout   <= w_cout;
          // r_carry here is the carry into bit 3
          r_ovf    <= r_carry ^ w_cout;
        end
      end else if (w_start_pulse) begin
        // Subtract is A + ~B + 1: invert B and seed the carry with the mode bit.
        r_a     <= ui_in[3:0];
        r_b     <= ui_in[7:4] ^ {4{w_mode}};
        r_carry <= w_mode;
        r_cnt   <= 2'd0;
      end
    end
  end

  assign uo_out  = {(r_state == DONE), (r_state == RUN), r_ovf, r_cout, r_result};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign w_unused = &{1'b0, uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_halfadder_serial_ctrl.sv
// tb/tb_tt_um_halfadder_serial_ctrl.sv - directed scoreboard bench for tt_um_halfadder_serial_ctrl
`timescale 1ns/1ps
module tb_tt_um_halfadder_serial_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];
  logic [7:0] last_exp = 8'h00;

  tt_um_halfadder_serial_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
    logic [3:0] bb;
    logic [4:0] s;
    logic       ovf;
    bb  = m ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + {4'd0, m};
    ovf = (a[3] == bb[3]) && (s[3] != a[3]);
    return {1'b1, 1'b0, ovf, s[4], s[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic m, input logic hold);
    ui_in  = {b, a};
    uio_in = {6'b0, m, 1'b1};
    sb_q.push_back(model(a, b, m));
    tick();
    chk({tag, "_busy_after_accept"}, {30'd0, uo_out[7:6]}, 32'h1);
    if (!hold) uio_in[0] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (uo_out[7] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_edges);
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      last_exp = sb_q.pop_front();
      chk(tag, {24'd0, uo_out}, {24'd0, last_exp});
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    chk("reset_uo_out", {24'd0, uo_out}, 32'h00);
    chk("reset_uio_out", {24'd0, uio_out}, 32'h00);
    chk("reset_uio_oe", {24'd0, uio_oe}, 32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {24'd0, uo_out}, 32'h00);

    start_op("add_5_3", 4'd5, 4'd3, 1'b0, 1'b0);
    wait_done("add_5_3", 4);

    start_op("add_15_1", 4'd15, 4'd1, 1'b0, 1'b0);
    wait_done("add_15_1", 4);

    // New op from DONE: result fields must keep the previous value while running
    start_op("sub_3_5", 4'd3, 4'd5, 1'b1, 1'b0);
    chk("result_hold_in_run", {26'd0, uo_out[5:0]}, {26'd0, last_exp[5:0]});
    wait_done("sub_3_5", 4);

    start_op("sub_5_5", 4'd5, 4'd5, 1'b1, 1'b0);
    wait_done("sub_5_5", 4);

    // Start held high for 20 cycles with operands changed mid-run
    start_op("hold", 4'd9, 4'd4, 1'b0, 1'b1);
    tick();
    ui_in = {4'd7, 4'd7};
    wait_done("hold", 3);
    for (int i = 0; i < 15; i++) tick();
    chk("hold_single_op", {24'd0, uo_out}, {24'd0, last_exp});
    uio_in[0] = 1'b0;
    tick();

    // Reset two edges into a run aborts it; start held through reset relaunches
    start_op("abort", 4'd9, 4'd6, 1'b0, 1'b0);
    tick();
    tick();
    uio_in = 8'h03;
    ui_in  = {4'd2, 4'd7};
    rst_n  = 1'b0;
    #1;
    chk("reset_async_clear", {24'd0, uo_out}, 32'h00);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    tick();
    chk("reset_held_clear", {24'd0, uo_out}, 32'h00);
    sb_q.push_back(model(4'd7, 4'd2, 1'b1));
    rst_n = 1'b1;
    tick();
    chk("restart_busy_after_reset", {30'd0, uo_out[7:6]}, 32'h1);
    uio_in[0] = 1'b0;
    wait_done("restart_sub_7_2", 4);

    // ena low for 3 cycles after the first RUN edge
    start_op("freeze", 4'd6, 4'd7, 1'b0, 1'b0);
    tick();
    ena = 1'b0;
    uio_in[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("freeze_busy_held", {24'd0, uo_out}, {24'd0, 8'h40 | {2'b00, last_exp[5:0]}});
    end
    uio_in[0] = 1'b0;
    ena = 1'b1;
    wait_done("freeze", 3);

    tick();
    ena = 1'b0;
    uio_in[0] = 1'b1;
    tick();
    chk("ena_low_ignores_start", {24'd0, uo_out}, {24'd0, last_exp});
    ena = 1'b1;
    uio_in[0] = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
